chacha20_block_sequencer: RTL

- Sequencer that turns one key/nonce/counter request into one 512-bit ChaCha20 keystream block.
- Builds the initial 16-word state and iterates the existing combinational double round (chacha20_column_and_diagonal_round) once per clock, DOUBLE_ROUNDS times.
- Adds the initial state to the working state and presents the result on a valid/ready output.
- Sits between the RNG/cipher front-end (requester) and the keystream consumer.

---
 rtl/chacha20_pkg.sv | 48 ++++
 rtl/chacha20_column_and_diagonal_round.sv | 51 +++++
 rtl/chacha20_state_add.sv | 19 +
 rtl/chacha20_block_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: state/word widths, sigma constants,
// state word indices, sequencer FSM encoding and the initial-state builder.
package chacha20_pkg;

    localparam int unsigned STATE_W    = 512;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned N_WORDS    = 16;
    localparam int unsigned KEY_WORDS  = 8;
    localparam int unsigned NONCE_WORDS = 3;

    localparam int unsigned KEY_BASE   = 4;
    localparam int unsigned CTR_IDX    = 12;
    localparam int unsigned NONCE_BASE = 13;

    localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Packs constants, key, counter and nonce; word i lives at [32i+31:32i].
    function automatic logic [STATE_W-1:0] build_state(
        input logic [KEY_WORDS*WORD_W-1:0]   key,
        input logic [NONCE_WORDS*WORD_W-1:0] nonce,
        input logic [WORD_W-1:0]             counter
    );
        logic [STATE_W-1:0] s;
        s = '0;
        s[0*WORD_W +: WORD_W] = SIGMA0;
        s[1*WORD_W +: WORD_W] = SIGMA1;
        s[2*WORD_W +: WORD_W] = SIGMA2;
        s[3*WORD_W +: WORD_W] = SIGMA3;
        for (int k = 0; k < int'(KEY_WORDS); k++) begin
            s[(int'(KEY_BASE) + k)*WORD_W +: WORD_W] = key[k*WORD_W +: WORD_W];
        end
        s[CTR_IDX*WORD_W +: WORD_W] = counter;
        for (int n = 0; n < int'(NONCE_WORDS); n++) begin
            s[(int'(NONCE_BASE) + n)*WORD_W +: WORD_W] = nonce[n*WORD_W +: WORD_W];
        end
        return s;
    endfunction

endpackage

// File: rtl/chacha20_column_and_diagonal_round.sv
// Combinational ChaCha20 double round: four column quarter rounds then
// four diagonal quarter rounds.
// Ports: state_in  - 512-bit working state, word i at [32i+31:32i]
//        state_out - state after one double round
module chacha20_column_and_diagonal_round
    import chacha20_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out
);

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Returns {a, b, c, d} after one quarter round.
    function automatic logic [4*WORD_W-1:0] qr(
        input logic [WORD_W-1:0] a_i,
        input logic [WORD_W-1:0] b_i,
        input logic [WORD_W-1:0] c_i,
        input logic [WORD_W-1:0] d_i
    );
        logic [WORD_W-1:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    always_comb begin : dround
        logic [WORD_W-1:0] w [N_WORDS];
        state_out = '0;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            w[i] = state_in[i*WORD_W +: WORD_W];
        end
        {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
        {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
        {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
        {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
        {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
        {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
        {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
        {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
        for (int i = 0; i < int'(N_WORDS); i++) begin
            state_out[i*WORD_W +: WORD_W] = w[i];
        end
    end

endmodule

// File: rtl/chacha20_state_add.sv
// Final feed-forward: 16 independent 32-bit modular adds, no inter-word carry.
// Ports: init_state - initial state, work_state - state after all rounds,
//        block_c    - keystream block (combinational)
module chacha20_state_add
    import chacha20_pkg::*;
(
    input  logic [STATE_W-1:0] init_state,
    input  logic [STATE_W-1:0] work_state,
    output logic [STATE_W-1:0] block_c
);

    always_comb begin
        block_c = '0;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            block_c[i*WORD_W +: WORD_W] = init_state[i*WORD_W +: WORD_W] + work_state[i*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/chacha20_block_sequencer.sv
// ChaCha20 block sequencer: accepts one key/nonce/counter request, iterates
// the double round DOUBLE_ROUNDS times, adds the initial state and holds the
// keystream block on a valid/ready output until consumed.
// Optional build macro CHACHA20_UNROLL2_EN chains two double rounds per cycle
// (DOUBLE_ROUNDS must then be even); the output value is the same.
// Ports: clock, reset (async, active high)
//        start_valid/start_ready, key[255:0], nonce[95:0], counter[31:0] - request
//        out_valid/out_ready, out_block[511:0]                           - keystream
//        busy - high in RUN or DONE
module chacha20_block_sequencer
    import chacha20_pkg::*;
#(
    parameter int unsigned DOUBLE_ROUNDS = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    input  logic [NONCE_WORDS*WORD_W-1:0] nonce,
    input  logic [WORD_W-1:0]             counter,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [STATE_W-1:0]            out_block,
    output logic                          busy
);

    localparam int unsigned CNT_W = 4;

    if (DOUBLE_ROUNDS < 1 || DOUBLE_ROUNDS > 15) begin : g_range_check
        $error("DOUBLE_ROUNDS must be in 1..15");
    end

    seq_state_t         state;
    logic [CNT_W-1:0]   round_cnt;
    logic [STATE_W-1:0] init_state;
    logic [STATE_W-1:0] work_state;
    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] final_block;

`ifdef CHACHA20_UNROLL2_EN
    localparam int unsigned RUN_CYCLES = DOUBLE_ROUNDS / 2;

    if ((DOUBLE_ROUNDS % 2) != 0) begin : g_even_check
        $error("DOUBLE_ROUNDS must be even when CHACHA20_UNROLL2_EN is defined");
    end

    logic [STATE_W-1:0] mid_state;

    chacha20_column_and_diagonal_round u_round0 (
        .state_in  (work_state),
        .state_out (mid_state)
    );

    chacha20_column_and_diagonal_round u_round1 (
        .state_in  (mid_state),
        .state_out (next_state)
    );
`else
    localparam int unsigned RUN_CYCLES = DOUBLE_ROUNDS;

    chacha20_column_and_diagonal_round u_round0 (
        .state_in  (work_state),
        .state_out (next_state)
    );
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES);

    // Feed-forward on the post-round value so DONE is entered on the final round edge.
    chacha20_state_add u_add (
        .init_state (init_state),
        .work_state (next_state),
        .block_c    (final_block)
    );

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_block   <= '0;
            init_state  <= '0;
            work_state  <= '0;
            round_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        init_state  <= build_state(key, nonce, counter);
                        work_state  <= build_state(key, nonce, counter);
                        round_cnt   <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    work_state <= next_state;
                    round_cnt  <= round_cnt + CNT_W'(1);
                    if (round_cnt + CNT_W'(1) == LAST_CNT) begin
                        out_block <= final_block;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    out_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
